// File: rtl/divider_sequencer.sv
// Table-driven clock divider sequencer: steps through four (ratio, repeat)
// entries, producing a divided square wave and a tick per divided period.
module divider_sequencer #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned REP_W = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_idx,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [REP_W-1:0] cfg_rep,
    output logic             tick,
    output logic             clkout,
    output logic             busy,
    output logic [1:0]       cur_idx,
    output logic             seq_done
);

    localparam int unsigned IDX_W = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Configuration table
    logic [WIDTH-1:0] div_tab [DEPTH];
    logic [REP_W-1:0] rep_tab [DEPTH];

    // Registered state
    state_t           state;
    logic [WIDTH-1:0] count;
    logic [REP_W-1:0] rep_cnt;
    logic [WIDTH-1:0] n_act;
    logic [REP_W-1:0] rep_act;
    logic             ran;

    // Next-state values
    state_t           state_d;
    logic [IDX_W-1:0] idx_d;
    logic [WIDTH-1:0] count_d;
    logic [REP_W-1:0] rep_cnt_d;
    logic [WIDTH-1:0] n_d;
    logic [REP_W-1:0] rep_d;
    logic             ran_d;
    logic             done_d;
    logic             period_end;
    logic             entry_end;
    logic [WIDTH-1:0] sel_div;
    logic [REP_W-1:0] sel_rep;

    // Table writes, accepted only while idle; never touch the active registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                div_tab[IDX_W'(i)] <= '0;
                rep_tab[IDX_W'(i)] <= '0;
            end
        end else if (cfg_valid && cfg_ready) begin
            div_tab[cfg_idx] <= cfg_div;
            rep_tab[cfg_idx] <= cfg_rep;
        end
    end

    // Next-state and counter logic; stop overrides every transition
    always_comb begin
        state_d    = state;
        idx_d      = cur_idx;
        count_d    = count;
        rep_cnt_d  = rep_cnt;
        n_d        = n_act;
        rep_d      = rep_act;
        ran_d      = ran;
        done_d     = 1'b0;
        period_end = (count == (n_act - WIDTH'(1)));
        entry_end  = period_end && (rep_cnt == (rep_act - REP_W'(1)));
        sel_div    = div_tab[cur_idx];
        sel_rep    = rep_tab[cur_idx];

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    ran_d   = 1'b0;
                end
            end
            LOAD: begin
                if (sel_rep != '0) begin
                    state_d   = RUN;
                    n_d       = (sel_div < WIDTH'(2)) ? WIDTH'(2) : sel_div;
                    rep_d     = sel_rep;
                    count_d   = '0;
                    rep_cnt_d = '0;
                    ran_d     = 1'b1;
                end else if (cur_idx != LAST_IDX) begin
                    idx_d = cur_idx + IDX_W'(1);
                end else if (loop_en && ran) begin
                    idx_d = '0;
                    ran_d = 1'b0;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            RUN: begin
                if (entry_end) begin
                    count_d   = '0;
                    rep_cnt_d = '0;
                    if (cur_idx != LAST_IDX) begin
                        state_d = LOAD;
                        idx_d   = cur_idx + IDX_W'(1);
                    end else if (loop_en) begin
                        state_d = LOAD;
                        idx_d   = '0;
                        ran_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    count_d = period_end ? '0 : count + WIDTH'(1);
                    if (period_end) begin
                        rep_cnt_d = rep_cnt + REP_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stop && (state != IDLE)) begin
            state_d   = IDLE;
            count_d   = '0;
            rep_cnt_d = '0;
            done_d    = 1'b0;
        end
    end

    // State and output registers; outputs are decoded from next-state values
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_idx   <= '0;
            count     <= '0;
            rep_cnt   <= '0;
            n_act     <= '0;
            rep_act   <= '0;
            ran       <= 1'b0;
            tick      <= 1'b0;
            clkout    <= 1'b0;
            busy      <= 1'b0;
            seq_done  <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            state     <= state_d;
            cur_idx   <= idx_d;
            count     <= count_d;
            rep_cnt   <= rep_cnt_d;
            n_act     <= n_d;
            rep_act   <= rep_d;
            ran       <= ran_d;
            tick      <= (state_d == RUN) && (count_d == (n_d - WIDTH'(1)));
            clkout    <= (state_d == RUN) && (count_d >= (n_d >> 1));
            busy      <= (state_d != IDLE);
            seq_done  <= done_d;
            cfg_ready <= (state_d == IDLE);
        end
    end

endmodule

// File: tb/tb_divider_sequencer.sv
// Scoreboard bench for divider_sequencer: a cycle-level event predictor feeds
// an expectation queue that a separate monitor drains on tick/seq_done.
module tb_divider_sequencer;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned REP_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             loop_en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_idx;
    logic [WIDTH-1:0] cfg_div;
    logic [REP_W-1:0] cfg_rep;
    logic             tick;
    logic             clkout;
    logic             busy;
    logic [1:0]       cur_idx;
    logic             seq_done;

    divider_sequencer #(.WIDTH(WIDTH), .REP_W(REP_W), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
        .cfg_div(cfg_div), .cfg_rep(cfg_rep), .tick(tick), .clkout(clkout),
        .busy(busy), .cur_idx(cur_idx), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        bit          done;
        int unsigned idx;
        int unsigned hi;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned m_div[4];
    int unsigned m_rep[4];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Walk the table by the sequencing rules and list every tick/done with its cycle
    task automatic predict(input int unsigned t, input bit lp, input int unsigned horizon);
        int unsigned now;
        int unsigned n;
        bit          ran;
        ev_t         e;
        now = t + 1;
        forever begin
            ran = 1'b0;
            for (int i = 0; i < 4; i++) begin
                now++;
                if (m_rep[i] != 0) begin
                    ran = 1'b1;
                    n = (m_div[i] < 2) ? 2 : m_div[i];
                    for (int k = 0; k < int'(m_rep[i]); k++) begin
                        e.cyc  = now + n - 1;
                        e.done = 1'b0;
                        e.idx  = i;
                        e.hi   = n - (n >> 1);
                        if (e.cyc <= horizon) exp_q.push_back(e);
                        now += n;
                    end
                end
                if (now > horizon) return;
            end
            if (!lp || !ran) begin
                e.cyc  = now;
                e.done = 1'b1;
                e.idx  = 0;
                e.hi   = 0;
                if (e.cyc <= horizon) exp_q.push_back(e);
                return;
            end
        end
    endtask

    // Monitor: compares each presented tick/seq_done against the queue head
    int unsigned hi = 0;
    always @(negedge clk) begin
        ev_t e;
        if (clkout === 1'b1) hi++;
        if (tick === 1'b1 || seq_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {62'd0, tick, seq_done}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("event_kind", {tick, seq_done}, {~e.done, e.done});
                if (!e.done) begin
                    check("tick_idx", cur_idx, e.idx);
                    check("clkout_high_cycles", hi, e.hi);
                end
            end
        end
        if (tick === 1'b1 || busy !== 1'b1) hi = 0;
    end

    task automatic wr(input int i, input int unsigned d, input int unsigned r);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_idx   = 2'(i);
        cfg_div   = WIDTH'(d);
        cfg_rep   = REP_W'(r);
        check("cfg_ready_idle", cfg_ready, 1);
        m_div[i] = d;
        m_rep[i] = r;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic run_seq(input bit lp, input int unsigned stop_rel, input int unsigned wr_rel,
                           input int unsigned rst_rel, input bit chk_load);
        int unsigned t;
        int unsigned hz;
        @(negedge clk);
        t  = cyc;
        hz = t + 20000;
        if (stop_rel != 0) hz = t + stop_rel;
        if (rst_rel != 0) hz = t + rst_rel;
        loop_en = lp;
        start   = 1'b1;
        predict(t, lp, hz);
        for (int k = 1; k <= 20000; k++) begin
            @(negedge clk);
            start     = 1'b0;
            stop      = 1'b0;
            rst       = 1'b0;
            cfg_valid = 1'b0;
            if (chk_load && k <= 4) begin
                check("skip_load_idx", cur_idx, k - 1);
                check("skip_load_busy", busy, 1);
                check("skip_load_clkout", clkout, 0);
            end
            if ((stop_rel != 0 && k == stop_rel + 1) || (rst_rel != 0 && k == rst_rel + 1)) begin
                check("abort_busy", busy, 0);
                check("abort_clkout", clkout, 0);
                check("abort_tick", tick, 0);
                check("abort_seq_done", seq_done, 0);
                check("abort_cfg_ready", cfg_ready, 1);
                if (rst_rel != 0) check("rst_cur_idx", cur_idx, 0);
            end
            if (k == stop_rel) stop = 1'b1;
            if (k == wr_rel) begin
                cfg_valid = 1'b1;
                cfg_idx   = 2'd0;
                cfg_div   = WIDTH'(9);
                cfg_rep   = REP_W'(5);
                check("cfg_ready_run", cfg_ready, 0);
            end
            if (k == rst_rel) begin
                rst = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    m_div[i] = 0;
                    m_rep[i] = 0;
                end
            end
            if (busy === 1'b0 && exp_q.size() == 0 && !stop && !rst) break;
        end
        check("sequence_drained", {62'd0, busy === 1'b0, exp_q.size() == 0}, 64'd3);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        bit          lp;
        int unsigned sr;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        cfg_valid = 1'b1; cfg_idx = 2'd1; cfg_div = '1; cfg_rep = '1;
        for (int i = 0; i < 4; i++) begin m_div[i] = 0; m_rep[i] = 0; end
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_tick", tick, 0);
        check("reset_clkout", clkout, 0);
        check("reset_seq_done", seq_done, 0);
        check("reset_cur_idx", cur_idx, 0);
        check("reset_cfg_ready", cfg_ready, 1);
        rst = 1'b0; cfg_valid = 1'b0;

        // Cleared table with no writes: four skip loads then done
        run_seq(1'b1, 0, 0, 0, 1'b1);

        // N=4 x2 on entry 0, rest skipped
        wr(0, 4, 2); wr(1, 7, 0); wr(2, 3, 0); wr(3, 0, 0);
        run_seq(1'b0, 0, 0, 0, 1'b0);

        // Odd N=5 then N=1 clamped to 2
        wr(0, 5, 1); wr(1, 1, 1);
        run_seq(1'b0, 0, 0, 0, 1'b0);

        // Looping single entry aborted on its second RUN cycle
        wr(0, 3, 1); wr(1, 0, 0);
        run_seq(1'b1, 3, 0, 0, 1'b0);

        // Start and stop together in IDLE stay idle
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        check("start_stop_busy", busy, 0);
        check("start_stop_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        check("start_stop_busy2", busy, 0);

        // Table write attempted mid-run is dropped; rerun proves old contents
        wr(0, 4, 3);
        run_seq(1'b0, 0, 3, 0, 1'b0);
        run_seq(1'b0, 0, 0, 0, 1'b0);

        // Wider ratio and repeat count
        wr(0, 300, 2); wr(2, 2, 7);
        run_seq(1'b0, 0, 0, 0, 1'b0);
        wr(2, 0, 0);

        // Randomized tables, loop and abort
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 4; i++)
                wr(i, $urandom_range(0, 9), ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3));
            lp = 1'($urandom_range(0, 1));
            sr = lp ? $urandom_range(4, 90) : 0;
            run_seq(lp, sr, 0, 0, 1'b0);
        end

        // Reset mid-run with N=6, then the cleared table runs the skip path
        wr(0, 6, 3); wr(1, 0, 0); wr(2, 0, 0); wr(3, 0, 0);
        run_seq(1'b0, 0, 0, 4, 1'b0);
        run_seq(1'b1, 0, 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
